// File: rtl/fp_alu_seq.sv
// Sequential floating-point add/multiply unit. Accepts one operation at a time, runs an
// align/add or shift-add multiply path, normalises, truncates and holds the result until taken.
module fp_alu_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int N  = MAN_W + 1;        // significand with hidden bit
  localparam int SW = MAN_W + 2;        // working significand: carry + hidden + frac
  localparam int XW = EXP_W + 2;        // signed working exponent
  localparam int PW = 2 * N;
  localparam int CW = $clog2(N + 1);

  localparam logic signed [XW-1:0] EMAX_X = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] BIAS_X = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] X_ONE  = XW'(1);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, MUL, NORM, PACK, DONE} state_t;

  state_t                 state;
  logic [W-1:0]           a_r, b_r;
  logic                   sign_r;
  logic signed [XW-1:0]   exp_r;
  logic [SW-1:0]          sig_r;
  logic [SW-1:0]          big_r, sml_r;
  logic                   sbig_r, ssml_r;
  logic [PW-1:0]          acc_r;
  logic [CW-1:0]          cnt_r;

  logic [EXP_W-1:0] ia_e, ib_e;
  assign ia_e = a[W-2 -: EXP_W];
  assign ib_e = b[W-2 -: EXP_W];

  logic [EXP_W-1:0] ea, eb, dexp;
  logic [SW-1:0]    ma_x, mb_x, sml_al;
  logic             a_ge;
  always_comb begin
    ea     = a_r[W-2 -: EXP_W];
    eb     = b_r[W-2 -: EXP_W];
    ma_x   = {2'b01, a_r[MAN_W-1:0]};
    mb_x   = {2'b01, b_r[MAN_W-1:0]};
    a_ge   = (ea >= eb);
    dexp   = a_ge ? ea - eb : eb - ea;
    sml_al = (int'(dexp) > MAN_W + 2) ? '0 : ((a_ge ? mb_x : ma_x) >> dexp);
  end

  logic [SW-1:0] add_mag;
  logic          add_sign;
  always_comb begin
    add_mag  = big_r + sml_r;
    add_sign = sbig_r;
    if (sbig_r != ssml_r) begin
      if (big_r >= sml_r) begin
        add_mag  = big_r - sml_r;
        add_sign = sbig_r;
      end else begin
        add_mag  = sml_r - big_r;
        add_sign = ssml_r;
      end
    end
  end

  // acc_r = {partial product high half, remaining multiplier bits}; shifts right once per cycle
  logic [N:0]    mul_sum;
  logic [PW-1:0] mul_nxt;
  always_comb begin
    mul_sum = {1'b0, acc_r[PW-1:N]} + (acc_r[0] ? {1'b0, ma_x[N-1:0]} : '0);
    mul_nxt = {mul_sum, acc_r[N-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      sign_r    <= 1'b0;
      exp_r     <= '0;
      sig_r     <= '0;
      big_r     <= '0;
      sml_r     <= '0;
      sbig_r    <= 1'b0;
      ssml_r    <= 1'b0;
      acc_r     <= '0;
      cnt_r     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r      <= a;
          b_r      <= b;
          in_ready <= 1'b0;
          sign_r   <= 1'b0;
          exp_r    <= '0;
          sig_r    <= '0;
          // special and zero operands are preloaded so PACK alone produces the answer
          if (&ia_e) begin
            sign_r <= a[W-1];
            exp_r  <= EMAX_X;
            state  <= PACK;
          end else if (&ib_e) begin
            sign_r <= b[W-1];
            exp_r  <= EMAX_X;
            state  <= PACK;
          end else if (ia_e == '0 || ib_e == '0) begin
            state <= PACK;
            if (!sel && ia_e != '0) begin
              sign_r <= a[W-1];
              exp_r  <= {2'b00, ia_e};
              sig_r  <= {2'b01, a[MAN_W-1:0]};
            end else if (!sel && ib_e != '0) begin
              sign_r <= b[W-1];
              exp_r  <= {2'b00, ib_e};
              sig_r  <= {2'b01, b[MAN_W-1:0]};
            end
          end else if (sel) begin
            acc_r <= {{N{1'b0}}, 1'b1, b[MAN_W-1:0]};
            cnt_r <= '0;
            state <= MUL;
          end else begin
            state <= ALIGN;
          end
        end
        ALIGN: begin
          exp_r  <= {2'b00, (a_ge ? ea : eb)};
          big_r  <= a_ge ? ma_x : mb_x;
          sml_r  <= sml_al;
          sbig_r <= a_ge ? a_r[W-1] : b_r[W-1];
          ssml_r <= a_ge ? b_r[W-1] : a_r[W-1];
          state  <= ADD;
        end
        ADD: begin
          sig_r  <= add_mag;
          sign_r <= add_sign;
          state  <= NORM;
        end
        MUL: begin
          acc_r <= mul_nxt;
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == CW'(N - 1)) begin
            sig_r  <= mul_nxt[PW-1 -: SW];
            exp_r  <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_X;
            sign_r <= a_r[W-1] ^ b_r[W-1];
            state  <= NORM;
          end
        end
        NORM: begin
          if (sig_r[SW-1]) begin
            sig_r <= sig_r >> 1;
            exp_r <= exp_r + X_ONE;
            state <= PACK;
          end else if (sig_r == '0) begin
            sign_r <= 1'b0;
            exp_r  <= '0;
            state  <= PACK;
          end else if (!sig_r[MAN_W]) begin
            sig_r <= sig_r << 1;
            exp_r <= exp_r - X_ONE;
          end else begin
            state <= PACK;
          end
        end
        PACK: begin
          if (exp_r >= EMAX_X) begin
            result   <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            overflow <= 1'b1;
          end else if (exp_r[XW-1] || exp_r == '0) begin
            result   <= '0;
            overflow <= 1'b0;
          end else begin
            result   <= {sign_r, exp_r[EXP_W-1:0], sig_r[MAN_W-1:0]};
            overflow <= 1'b0;
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_alu_seq.sv
// Directed and randomized checks of fp_alu_seq against an arithmetic reference model.
module tb_fp_alu_seq;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int W = 1 + EXP_W + MAN_W;

  logic         clk, rst_n, sel, in_valid, in_ready, overflow, out_valid, out_ready;
  logic [W-1:0] a, b, result;
  int checks = 0;
  int failures = 0;

  fp_alu_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .result(result), .overflow(overflow),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: value-level arithmetic on integer significands, truncating toward zero.
  function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic s,
                                output logic [31:0] r, output logic o);
    int ex, ey, e, d;
    longint mx, my, big, sml, mag;
    bit sx, sy, sb, ss, sg;
    ex = int'(x[30:23]); ey = int'(y[30:23]);
    sx = x[31]; sy = y[31];
    r = '0; o = 1'b0;
    if (ex == 255) begin r = {sx, 8'hFF, 23'd0}; o = 1'b1; return; end
    if (ey == 255) begin r = {sy, 8'hFF, 23'd0}; o = 1'b1; return; end
    if (ex == 0 || ey == 0) begin
      if (!s && !(ex == 0 && ey == 0)) r = (ex == 0) ? y : x;
      return;
    end
    mx = longint'(x[22:0]) + (64'd1 << 23);
    my = longint'(y[22:0]) + (64'd1 << 23);
    if (!s) begin
      if (ex >= ey) begin e = ex; d = ex - ey; big = mx; sml = my; sb = sx; ss = sy; end
      else          begin e = ey; d = ey - ex; big = my; sml = mx; sb = sy; ss = sx; end
      sml = (d > 25) ? 64'd0 : (sml >> d);
      if (sb == ss)        begin mag = big + sml; sg = sb; end
      else if (big >= sml) begin mag = big - sml; sg = sb; end
      else                 begin mag = sml - big; sg = ss; end
      if (mag == 0) return;
    end else begin
      mag = (mx * my) >> 23;
      e = ex + ey - 127;
      sg = sx ^ sy;
    end
    while (mag >= (64'd1 << 24)) begin mag = mag >> 1; e++; end
    while (mag < (64'd1 << 23))  begin mag = mag << 1; e--; end
    if (e >= 255)    begin r = {sg, 8'hFF, 23'd0}; o = 1'b1; end
    else if (e <= 0) r = '0;
    else             r = {sg, e[7:0], mag[22:0]};
  endfunction

  function automatic logic [31:0] rnd_fp(input int base);
    logic [31:0] v;
    int e;
    if (base > 0) e = base + int'($urandom_range(0, 2)) - 1;
    else if ($urandom_range(0, 5) == 0) e = int'($urandom_range(1, 254));
    else e = int'($urandom_range(100, 154));
    if ($urandom_range(0, 9) == 0) e = 0;
    if (e > 254) e = 254;
    v = $urandom;
    v[30:23] = e[7:0];
    return v;
  endfunction

  // One handshake-complete operation; the operand inputs are scrambled right after acceptance.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                        input logic [31:0] er, input logic eo, input string tag);
    int lat, lo, hi;
    bit byp;
    byp = (x[30:23] == 8'h00) || (y[30:23] == 8'h00) || (x[30:23] == 8'hFF) || (y[30:23] == 8'hFF);
    if (byp)    begin lo = 2;         hi = 2;         end
    else if (s) begin lo = MAN_W + 4; hi = MAN_W + 5; end
    else        begin lo = 3;         hi = MAN_W + 6; end
    chk({tag, " in_ready"}, in_ready, 1);
    a = x; b = y; sel = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; sel = ~s;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " out_valid"}, out_valid, 1);
    chk({tag, " result"}, result, er);
    chk({tag, " overflow"}, overflow, eo);
    checks++;
    assert (lat >= lo && lat <= hi) else begin
      failures++;
      $error("FAIL %s latency observed=%0d expected=%0d..%0d", tag, lat, lo, hi);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " idle out_valid"}, out_valid, 0);
    chk({tag, " idle in_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [31:0] x, y, er;
    logic        s, eo;
    int          seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset result", result, 0);
    chk("reset overflow", overflow, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset in_ready", in_ready, 1);

    run_op(32'h00000000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, "zero_add");
    run_op(32'h00000000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, "zero_mul");
    run_op(32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, "zero_zero_add");
    run_op(32'hC0490FDB, 32'h00000000, 1'b0, 32'hC0490FDB, 1'b0, "add_b_zero");
    run_op(32'hBF000000, 32'hC0CCCCCC, 1'b0, 32'hC0DCCCCC, 1'b0, "neg_add_trunc");
    run_op(32'h40000000, 32'h40400000, 1'b1, 32'h40C00000, 1'b0, "mul_2x3");
    run_op(32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 1'b0, "cancel");
    run_op(32'h7F000000, 32'h40000000, 1'b1, 32'h7F800000, 1'b1, "mul_ovf");
    run_op(32'h00800000, 32'h00800000, 1'b1, 32'h00000000, 1'b0, "mul_unf");
    run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, "add_ovf");
    run_op(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 1'b1, "inf_add");
    run_op(32'h40000000, 32'h7FC00000, 1'b1, 32'h7F800000, 1'b1, "nan_mul");
    run_op(32'h4C800000, 32'h3F800000, 1'b0, 32'h4C800000, 1'b0, "align_far");
    run_op(32'h3F800001, 32'hBF800000, 1'b0, 32'h34000000, 1'b0, "max_norm");

    // result must hold while the consumer stalls, and new requests are ignored
    a = 32'h40000000; b = 32'h40400000; sel = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 0;
    while (out_valid !== 1'b1 && seen < 100) begin @(posedge clk); #1; seen++; end
    chk("stall first result", result, 32'h40C00000);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; sel = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("stall%0d result", i), result, 32'h40C00000);
      chk($sformatf("stall%0d out_valid", i), out_valid, 1);
      chk($sformatf("stall%0d in_ready", i), in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("stall release in_ready", in_ready, 1);
    run_op(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, "after_stall");

    // reset in the middle of a multiply aborts it
    a = 32'h40000000; b = 32'h40400000; sel = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("abort out_valid", out_valid, 0);
    chk("abort result", result, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort in_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    chk("abort no out_valid", seen, 0);
    run_op(32'h40000000, 32'h40400000, 1'b1, 32'h40C00000, 1'b0, "post_abort_mul");

    for (int i = 0; i < 40; i++) begin
      x = rnd_fp(0);
      y = (i % 3 == 0) ? rnd_fp(int'(x[30:23])) : rnd_fp(0);
      s = 1'($urandom_range(0, 1));
      model(x, y, s, er, eo);
      run_op(x, y, s, er, eo, $sformatf("rnd%0d %h %s %h", i, x, s ? "*" : "+", y));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
